// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and widths for the two-port memory arbiter.
package mem_arbiter_pkg;
    localparam int XLEN = 32;
    localparam int BE_W = 4;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/mem_arbiter_arb.sv
// arb_rr2: two-input round-robin selector; on contention the previous loser wins.
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic   req_if_i,
    input  logic   req_dm_i,
    input  owner_t last_owner_i,
    output owner_t winner_o
);
    assign winner_o = (req_if_i && req_dm_i) ? ((last_owner_i == OWN_IF) ? OWN_DM : OWN_IF)
                                             : (req_dm_i ? OWN_DM : OWN_IF);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data memory,
// one outstanding transaction, with a response timeout that raises bus_err.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    input  logic [BE_W-1:0] dm_be,
    output logic            dm_gnt,
    output logic            dm_rvalid,
    output logic [XLEN-1:0] dm_rdata,
    output logic            bus_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [BE_W-1:0] mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    owner_t          owner_q, owner_d, last_q, last_d, win;
    logic [7:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata;
    logic [BE_W-1:0] be_q, be_d;
    logic            we_q, we_d, gnt, rsp, err, to_hit;

    arb_rr2 u_arb (
        .req_if_i    (if_req),
        .req_dm_i    (dm_req),
        .last_owner_i(last_q),
        .winner_o    (win)
    );

    assign to_hit = cnt_q == TO_LAST;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        gnt     = 1'b0;
        rsp     = 1'b0;
        err     = 1'b0;
        rdata   = '0;
        case (state_q)
            IDLE: if (if_req || dm_req) begin
                owner_d = win;
                last_d  = win;
                cnt_d   = '0;
                addr_d  = (win == OWN_DM) ? dm_addr : if_addr;
                wdata_d = (win == OWN_DM) ? dm_wdata : '0;
                be_d    = (win == OWN_DM) ? dm_be : '1;
                we_d    = (win == OWN_DM) && dm_we;
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d = cnt_q + 8'd1;
                // A grant in the timeout cycle still wins; the counter keeps running.
                if (mem_gnt) begin
                    gnt     = 1'b1;
                    state_d = WAIT_RSP;
                end else if (to_hit) begin
                    rsp     = 1'b1;
                    err     = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_RSP: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_rvalid) begin
                    rsp     = 1'b1;
                    rdata   = mem_rdata;
                    state_d = IDLE;
                end else if (to_hit) begin
                    rsp     = 1'b1;
                    err     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            last_q  <= OWN_IF;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
        end
    end

    assign mem_req   = state_q == ISSUE;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign bus_err   = err;
    assign if_gnt    = gnt && (owner_q == OWN_IF);
    assign dm_gnt    = gnt && (owner_q == OWN_DM);
    assign if_rvalid = rsp && (owner_q == OWN_IF);
    assign dm_rvalid = rsp && (owner_q == OWN_DM);
    assign if_rdata  = if_rvalid ? rdata : '0;
    assign dm_rdata  = dm_rvalid ? rdata : '0;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 64, response-wait cycle limit before a bus error is declared (range 2..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 if_req  in  1  instruction-fetch request.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_gnt  out  1  fetch request accepted by memory (one-cycle pulse).
REQ-007 if_rvalid  out  1  fetch response valid (one-cycle pulse).
REQ-008 if_rdata  out  32  fetch response data.
REQ-009 dm_req  in  1  data-memory request.
REQ-010 dm_we  in  1  1 = store, 0 = load.
REQ-011 dm_addr / dm_wdata  in  32 / 32  data address / store data.
REQ-012 dm_be  in  4  store byte enables.
REQ-013 dm_gnt / dm_rvalid  out  1 / 1  data accept pulse / response pulse (loads and stores).
REQ-014 dm_rdata  out  32  load data.
REQ-015 bus_err  out  1  timeout pulse, coincident with the owner's rvalid.
REQ-016 mem_req / mem_we  out  1 / 1  unified-memory request / write.
REQ-017 mem_addr / mem_wdata  out  32 / 32  memory address / write data.
REQ-018 mem_be  out  4  memory byte enables (4'hF for fetches).
REQ-019 mem_gnt / mem_rvalid  in  1 / 1  memory accept / response (response given for stores too).
REQ-020 mem_rdata  in  32  memory read data.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT_RSP; a single outstanding transaction at any time.
REQ-022 IDLE, any request active: select the owner, latch its addr/wdata/be/we into internal registers, go to ISSUE.
REQ-023 Single requester: that requester wins; on contention, the requester that did not win the previous transaction wins (round-robin); last_owner reset value = IF, so DM wins the first contention.
REQ-024 ISSUE: mem_req=1 with latched fields; when mem_gnt=1, the owner's gnt pulses that cycle and the FSM goes to WAIT_RSP.
REQ-025 WAIT_RSP: mem_rvalid=1 drives owner rvalid=1 and owner rdata=mem_rdata combinationally in the same cycle; next state IDLE.
REQ-026 Non-owner gnt/rvalid are held 0; rdata outputs are 0 when their rvalid is 0.
REQ-027 Minimum latency: request seen in IDLE at cycle N -> mem_req at N+1 -> rvalid at N+2 (mem_gnt at N+1, mem_rvalid at N+2); back-to-back transactions separated by one IDLE cycle.
REQ-028 Requesters hold req and fields stable until gnt; a req dropped before gnt does not cancel a latched transaction.
REQ-029 Timeout counter: 8-bit, cleared on IDLE->ISSUE, increments each cycle in ISSUE and WAIT_RSP; at count == TIMEOUT-1 with no completion: owner rvalid=1, rdata=0, bus_err=1 for one cycle, mem_req dropped, next state IDLE.
REQ-030 mem_gnt and timeout in the same cycle: mem_gnt takes priority (transition to WAIT_RSP, counter continues); mem_rvalid outside WAIT_RSP is ignored.

Reset
REQ-031 rst low asynchronously forces state=IDLE, last_owner=IF, counter=0, latched fields=0; all outputs 0 during reset.
REQ-032 Reset mid-transaction abandons it with no rvalid issued; first arbitration occurs on the first rising edge after rst deasserts.

Structure
REQ-033 Shared package holds: state_t enum {IDLE, ISSUE, WAIT_RSP}, owner_t enum {OWN_IF, OWN_DM}, XLEN=32, BE_W=4.
REQ-034 One sub-module, arb_rr2: 2-input round-robin selector (req_if, req_dm, last_owner -> winner), purely combinational.

Verification
REQ-035 if_req only, addr 0x10; mem_gnt immediate, mem_rdata 0x00500093 next cycle -> if_gnt at N+1, if_rvalid + if_rdata 0x00500093 at N+2, dm_* quiet.
REQ-036 if_req and dm_req both held from reset release -> DM wins first, IF second, DM third; each waits for the previous rvalid.
REQ-037 dm store, addr 0x20, wdata 0xDEADBEEF, be 4'b0011 -> mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; dm_rvalid on memory ack, dm_rdata=0.
REQ-038 mem_gnt withheld, TIMEOUT=8 -> after 8 cycles bus_err=1 and owner rvalid=1 with rdata 0, mem_req low the following cycle, FSM back in IDLE.
REQ-039 rst pulled low while in WAIT_RSP -> outputs 0 immediately, no rvalid; after release, a new request completes normally.
